// File: rtl/os_drain_collector_pkg.sv
// Shared types and defaults for the systolic array drain collector.
package os_drain_collector_pkg;

   localparam int ROWS_D  = 4;
   localparam int COLS_D  = 4;
   localparam int P_W_D   = 32;
   localparam int DEPTH_D = 4;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_DONE    = 2'd2
   } state_t;

   function automatic int res_w(int p_w, int cols);
      return p_w + $clog2(cols);
   endfunction

endpackage

// File: rtl/os_drain_collector_if.sv
// Merged result stream leaving the drain collector.
interface os_drain_collector_if
   import os_drain_collector_pkg::*;
#(
   parameter int ROWS = ROWS_D,
   parameter int COLS = COLS_D,
   parameter int P_W  = P_W_D
);
   localparam int RW = $clog2(ROWS);
   localparam int CW = $clog2(COLS);

   logic          out_valid;
   logic          out_ready;
   logic [P_W-1:0] out_data;
   logic [RW-1:0] out_row;
   logic [CW-1:0] out_col;

   modport master (
      output out_valid, out_data,
      output out_row, out_col,
      input  out_ready
   );

   modport slave (
      input  out_valid, out_data,
      input  out_row, out_col,
      output out_ready
   );

endinterface

// File: rtl/os_drain_fifo.sv
// Per-row sync FIFO; a push into a full FIFO is taken when the
// same row pops in that cycle.
module os_drain_fifo
   import os_drain_collector_pkg::*;
#(
   parameter int W     = res_w(P_W_D, COLS_D),
   parameter int DEPTH = DEPTH_D
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] wdata,
   output logic [W-1:0] rdata,
   output logic         full,
   output logic         empty
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic [AW:0]   cnt;
   logic          wr, rd;

   assign full  = (cnt == (AW+1)'(DEPTH));
   assign empty = (cnt == '0);
   assign rd    = pop && !empty;
   assign wr    = push && (!full || rd);
   assign rdata = mem[rp];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else begin
         if (wr) wp <= wp + AW'(1);
         if (rd) rp <= rp + AW'(1);
         cnt <= cnt + (AW+1)'(wr) - (AW+1)'(rd);
      end
   end

   always_ff @(posedge clk) begin
      if (wr) mem[wp] <= wdata;
   end

endmodule

// File: rtl/os_drain_collector.sv
// Collects per-row drain streams of an output-stationary array
// and merges them round-robin into one tagged result stream.
module os_drain_collector
   import os_drain_collector_pkg::*;
#(
   parameter int ROWS  = ROWS_D,
   parameter int COLS  = COLS_D,
   parameter int P_W   = P_W_D,
   parameter int DEPTH = DEPTH_D
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              tile_start,
   input  logic [ROWS-1:0]   drain_valid,
   input  logic [ROWS*P_W-1:0] drain_data,
   os_drain_collector_if.master out,
   output logic              busy,
   output logic              tile_done,
   output logic              err_ovf
);
   localparam int RW    = $clog2(ROWS);
   localparam int CW    = $clog2(COLS);
   localparam int NW    = $clog2(COLS+1);
   localparam int EW    = $clog2(ROWS*COLS+1);
   localparam int W     = res_w(P_W, COLS);
   localparam int TOTAL = ROWS*COLS;

   state_t        state;
   logic [NW-1:0] arr [ROWS];
   logic [EW-1:0] emit;
   logic [RW-1:0] rr, lrow, gnt;
   logic          lock, gv, hs, collect;

   logic [ROWS-1:0] full, empty;
   logic [ROWS-1:0] push, pop, drop;
   logic [W-1:0]    wdata [ROWS];
   logic [W-1:0]    rdata [ROWS];

   // Lowest offset from rr wins; a stalled grant stays locked.
   always_comb begin
      int j;
      j   = 0;
      gnt = '0;
      gv  = 1'b0;
      if (lock) begin
         gnt = lrow;
         gv  = 1'b1;
      end else begin
         for (int i = ROWS-1; i >= 0; i--) begin
            j = int'(rr) + i;
            if (j >= ROWS) j = j - ROWS;
            if (!empty[j]) begin
               gnt = RW'(j);
               gv  = 1'b1;
            end
         end
      end
   end

   assign collect       = (state == S_COLLECT);
   assign hs            = gv && out.out_ready;
   assign out.out_valid = gv;
   assign out.out_row   = gv ? gnt : '0;
   assign out.out_data  = gv ? rdata[gnt][P_W-1:0] : '0;
   assign out.out_col   = gv ? rdata[gnt][W-1:P_W] : '0;

   for (genvar r = 0; r < ROWS; r++) begin : g_row
      assign pop[r]  = hs && (gnt == RW'(r));
      assign push[r] = drain_valid[r] && collect &&
                       (arr[r] != NW'(COLS)) &&
                       (!full[r] || pop[r]);
      assign drop[r] = drain_valid[r] && !push[r];
      assign wdata[r] = {
         CW'(NW'(COLS-1) - arr[r]),
         drain_data[r*P_W +: P_W]
      };

      os_drain_fifo #(
         .W     (W),
         .DEPTH (DEPTH)
      ) u_fifo (
         .clk   (clk),
         .rst_n (rst_n),
         .push  (push[r]),
         .pop   (pop[r]),
         .wdata (wdata[r]),
         .rdata (rdata[r]),
         .full  (full[r]),
         .empty (empty[r])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         emit      <= '0;
         rr        <= '0;
         lock      <= 1'b0;
         lrow      <= '0;
         busy      <= 1'b0;
         tile_done <= 1'b0;
         err_ovf   <= 1'b0;
         for (int r = 0; r < ROWS; r++) arr[r] <= '0;
      end else begin
         tile_done <= 1'b0;
         lock      <= gv && !out.out_ready;
         lrow      <= gnt;
         if (|drop) err_ovf <= 1'b1;
         if (hs) begin
            rr <= (gnt == RW'(ROWS-1)) ? '0 : gnt + RW'(1);
         end
         for (int r = 0; r < ROWS; r++) begin
            if (push[r]) arr[r] <= arr[r] + NW'(1);
         end
         unique case (state)
            S_IDLE: begin
               if (tile_start) begin
                  state <= S_COLLECT;
                  busy  <= 1'b1;
                  emit  <= '0;
                  for (int r = 0; r < ROWS; r++) arr[r] <= '0;
               end
            end
            S_COLLECT: begin
               if (hs) begin
                  emit <= emit + EW'(1);
                  if (emit == EW'(TOTAL-1)) begin
                     state     <= S_DONE;
                     busy      <= 1'b0;
                     tile_done <= 1'b1;
                  end
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_os_drain_collector.sv
// Bench for os_drain_collector: DEPTH=4 and DEPTH=2 copies in lockstep.
module tb_os_drain_collector;
   localparam int ROWS = 4;
   localparam int COLS = 4;
   localparam int P_W  = 32;

   typedef struct {
      logic [31:0] data;
      int          col;
   } ent_t;

   typedef struct {
      int          row;
      int          col;
      logic [31:0] data;
   } hs_t;

   typedef struct {
      bit           ts;
      logic [3:0]   dv;
      logic [127:0] dd;
      bit           ev, eb, ed;
      int           er, ec;
      logic [31:0]  edat;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         ts, rdy;
   logic [3:0]   dv;
   logic [127:0] dd;

   logic        ov [2];
   logic [31:0] od [2];
   logic [1:0]  orow [2];
   logic [1:0]  ocol [2];
   logic        bz [2];
   logic        dn [2];
   logic        er [2];

   int total = 0;
   int bad   = 0;

   os_drain_collector_if #(.ROWS(ROWS), .COLS(COLS), .P_W(P_W)) b0 ();
   os_drain_collector_if #(.ROWS(ROWS), .COLS(COLS), .P_W(P_W)) b1 ();

   assign b0.out_ready = rdy;
   assign b1.out_ready = rdy;
   assign ov[0] = b0.out_valid;
   assign od[0] = b0.out_data;
   assign orow[0] = b0.out_row;
   assign ocol[0] = b0.out_col;
   assign ov[1] = b1.out_valid;
   assign od[1] = b1.out_data;
   assign orow[1] = b1.out_row;
   assign ocol[1] = b1.out_col;

   os_drain_collector #(
      .ROWS(ROWS), .COLS(COLS), .P_W(P_W), .DEPTH(4)
   ) u0 (
      .clk(clk), .rst_n(rst_n), .tile_start(ts),
      .drain_valid(dv), .drain_data(dd), .out(b0),
      .busy(bz[0]), .tile_done(dn[0]), .err_ovf(er[0])
   );

   os_drain_collector #(
      .ROWS(ROWS), .COLS(COLS), .P_W(P_W), .DEPTH(2)
   ) u1 (
      .clk(clk), .rst_n(rst_n), .tile_start(ts),
      .drain_valid(dv), .drain_data(dd), .out(b1),
      .busy(bz[1]), .tile_done(dn[1]), .err_ovf(er[1])
   );

   always #5 clk = ~clk;

   // reference model: per-row queues and plain counters
   ent_t mq [2][ROWS][$];
   int   ph [2];
   int   marr [2][ROWS];
   int   memit [2];
   int   mrr [2];
   int   mlk [2];
   int   mlr [2];
   bit   merr [2];
   int   depth [2] = '{4, 2};

   vec_t tbl [19];
   hs_t  hs0 [$];
   bit   logon = 1'b0;

   function automatic int m_gnt(int d);
      if (mlk[d] != 0) return mlr[d];
      for (int i = 0; i < ROWS; i++) begin
         if (mq[d][(mrr[d] + i) % ROWS].size() > 0)
            return (mrr[d] + i) % ROWS;
      end
      return -1;
   endfunction

   task automatic m_reset();
      for (int d = 0; d < 2; d++) begin
         for (int r = 0; r < ROWS; r++) begin
            mq[d][r].delete();
            marr[d][r] = 0;
         end
         ph[d] = 0; memit[d] = 0; mrr[d] = 0;
         mlk[d] = 0; mlr[d] = 0; merr[d] = 1'b0;
      end
   endtask

   task automatic m_check(int d);
      int g;
      logic [39:0] a, w;
      g = m_gnt(d);
      a = {ov[d], orow[d], ocol[d], od[d], bz[d], dn[d], er[d]};
      if (g >= 0)
         w = {1'b1, 2'(g), 2'(mq[d][g][0].col), mq[d][g][0].data,
              ph[d] == 1, ph[d] == 2, merr[d]};
      else
         w = {1'b0, 2'd0, 2'd0, 32'd0, ph[d] == 1, ph[d] == 2, merr[d]};
      total++;
      if (a !== w) begin
         bad++;
         $display("FAIL model dut%0d t=%0t got v=%b r=%0d c=%0d d=%h b=%b dn=%b e=%b want v=%b r=%0d c=%0d d=%h b=%b dn=%b e=%b",
                  d, $time, a[39], a[38:37], a[36:35], a[34:3], a[2], a[1], a[0],
                  w[39], w[38:37], w[36:35], w[34:3], w[2], w[1], w[0]);
      end
   endtask

   task automatic m_step(int d);
      int g, old;
      bit hs;
      g   = m_gnt(d);
      hs  = (g >= 0) && rdy;
      old = ph[d];
      if (hs) mq[d][g].delete(0);
      for (int r = 0; r < ROWS; r++) begin
         if (dv[r]) begin
            if (old == 1 && marr[d][r] < COLS && mq[d][r].size() < depth[d]) begin
               mq[d][r].push_back('{data: dd[r*32 +: 32], col: COLS-1-marr[d][r]});
               marr[d][r]++;
            end else merr[d] = 1'b1;
         end
      end
      mlk[d] = (g >= 0 && !rdy) ? 1 : 0;
      mlr[d] = g;
      if (hs) begin
         mrr[d] = (g + 1) % ROWS;
         memit[d]++;
      end
      case (old)
         0: if (ts) begin
               ph[d] = 1; memit[d] = 0;
               for (int r = 0; r < ROWS; r++) marr[d][r] = 0;
            end
         1: if (hs && memit[d] == ROWS*COLS) ph[d] = 2;
         default: ph[d] = 0;
      endcase
   endtask

   task automatic chk(string nm, logic [63:0] got, logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", nm, got, want);
      end
   endtask

   task automatic tick(int c);
      @(negedge clk);
      if (c >= 0) begin
         total++;
         if ({ov[0], 2'(orow[0]), 2'(ocol[0]), od[0], bz[0], dn[0]} !==
             {tbl[c].ev, 2'(tbl[c].er), 2'(tbl[c].ec), tbl[c].edat, tbl[c].eb, tbl[c].ed}) begin
            bad++;
            $display("FAIL tbl c=%0d got v=%b r=%0d c=%0d d=%0d b=%b dn=%b want v=%b r=%0d c=%0d d=%0d b=%b dn=%b",
                     c, ov[0], orow[0], ocol[0], od[0], bz[0], dn[0], tbl[c].ev,
                     tbl[c].er, tbl[c].ec, tbl[c].edat, tbl[c].eb, tbl[c].ed);
         end
      end
      if (logon && ov[0] && rdy)
         hs0.push_back('{row: int'(orow[0]), col: int'(ocol[0]), data: od[0]});
      for (int d = 0; d < 2; d++) begin
         m_check(d);
         if (rst_n) m_step(d);
         else m_reset();
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      ts = 1'b0; dv = '0; dd = '0;
   endtask

   task automatic check_zero(string nm);
      for (int d = 0; d < 2; d++)
         chk(nm, 64'({ov[d], od[d], orow[d], ocol[d], bz[d], dn[d], er[d]}), 64'd0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle_in();
      #1;
      check_zero("rst_async");
      m_reset();
      tick(-1);
      tick(-1);
      rst_n = 1'b1;
      tick(-1);
   endtask

   task automatic build_tbl();
      int k, i;
      for (int c = 0; c < 19; c++) begin
         tbl[c] = '{default: '0};
         tbl[c].ts = (c == 0);
         for (int r = 0; r < ROWS; r++) begin
            k = c - 1 - r;
            if (k >= 0 && k < COLS) begin
               tbl[c].dv[r] = 1'b1;
               tbl[c].dd[r*32 +: 32] = 32'(16*r + k);
            end
         end
         tbl[c].ev = (c >= 2 && c <= 17);
         tbl[c].eb = (c >= 1 && c <= 17);
         tbl[c].ed = (c == 18);
         if (tbl[c].ev) begin
            i = c - 2;
            tbl[c].er = i % 4;
            tbl[c].ec = 3 - i / 4;
            tbl[c].edat = 32'(16*(i % 4) + i / 4);
         end
      end
   endtask

   task automatic run_tbl(int xr, int xc, int last);
      rdy = 1'b1;
      for (int c = 0; c <= last; c++) begin
         ts = tbl[c].ts; dv = tbl[c].dv; dd = tbl[c].dd;
         if (c == xc) begin
            dv[xr] = 1'b1;
            dd[xr*32 +: 32] = 32'hdead_beef;
         end
         tick(c);
      end
      idle_in();
   endtask

   initial begin
      int sent [ROWS];
      int n;
      rst_n = 1'b0; rdy = 1'b1;
      idle_in();
      m_reset();
      build_tbl();
      repeat (2) @(posedge clk);
      #1;
      check_zero("reset");
      rst_n = 1'b1;
      tick(-1);

      // wavefront tile, table expectations
      run_tbl(0, -1, 18);
      tick(-1);
      chk("t1_err", 64'(er[0]), 64'd0);

      // 20-cycle stall then round-robin release
      do_reset();
      rdy = 1'b0;
      ts = 1'b1; tick(-1); ts = 1'b0;
      for (int k = 0; k < 4; k++) begin
         dv = 4'hF;
         for (int r = 0; r < ROWS; r++) dd[r*32 +: 32] = 32'(16*r + k);
         tick(-1);
      end
      idle_in();
      repeat (16) tick(-1);
      chk("t2_hold", 64'({ov[0], orow[0], ocol[0], od[0]}), 64'({1'b1, 2'd0, 2'd3, 32'd0}));
      chk("t2_noerr", 64'(er[0]), 64'd0);
      chk("t2_d2_err", 64'(er[1]), 64'd1);
      hs0.delete();
      logon = 1'b1;
      rdy = 1'b1;
      n = 0;
      while (ph[0] != 0 && n < 40) begin tick(-1); n++; end
      logon = 1'b0;
      chk("t2_timeout", 64'(n < 40), 64'd1);
      chk("t2_count", 64'(hs0.size()), 64'd16);
      foreach (hs0[i])
         chk("t5_rr", 64'({hs0[i].row, hs0[i].col, hs0[i].data}),
             64'({i % 4, 3 - i / 4, 32'(16*(i % 4) + i / 4)}));

      // DEPTH=2: push into full with pop accepted, without pop dropped
      do_reset();
      ts = 1'b1; tick(-1); ts = 1'b0;
      rdy = 1'b0; dv = 4'b0001; dd[31:0] = 32'd100; tick(-1);
      dd[31:0] = 32'd101; tick(-1);
      rdy = 1'b1; dd[31:0] = 32'd102; tick(-1);
      chk("t4_full_pop_ok", 64'(er[1]), 64'd0);
      rdy = 1'b0; dd[31:0] = 32'd103; tick(-1);
      idle_in();
      chk("t4_full_drop", 64'(er[1]), 64'd1);
      chk("t4_d4_noerr", 64'(er[0]), 64'd0);
      for (int k = 0; k < 12; k++) begin
         rdy = k[0]; dv = 4'hF; dd = {4{$urandom}};
         tick(-1);
      end
      idle_in();

      // beat while idle and a 5th beat on row 2
      do_reset();
      dv = 4'b0010; tick(-1); idle_in();
      chk("t3_idle_drop", 64'(er[0]), 64'd1);
      run_tbl(2, 7, 18);
      tick(-1);
      chk("t3_sticky", 64'(er[0]), 64'd1);

      // reset after 7 results, then a clean tile
      do_reset();
      run_tbl(0, -1, 8);
      rst_n = 1'b0;
      #1;
      check_zero("t6_async");
      m_reset();
      tick(-1);
      rst_n = 1'b1;
      tick(-1);
      run_tbl(0, -1, 18);

      // random tiles
      for (int t = 0; t < 8; t++) begin
         do_reset();
         ts = 1'b1; tick(-1); ts = 1'b0;
         for (int r = 0; r < ROWS; r++) sent[r] = 0;
         n = 0;
         while (ph[0] != 0 && n < 400) begin
            rdy = ($urandom_range(3) != 0) || (t == 0);
            ts = ($urandom_range(19) == 0);
            dv = '0;
            for (int r = 0; r < ROWS; r++) begin
               if (sent[r] < COLS && mq[0][r].size() < 3 && $urandom_range(1) == 1) begin
                  dv[r] = 1'b1; sent[r]++;
               end else if (sent[r] == COLS && $urandom_range(49) == 0) dv[r] = 1'b1;
               dd[r*32 +: 32] = $urandom;
            end
            tick(-1);
            n++;
         end
         idle_in();
         chk("rand_timeout", 64'(n < 400), 64'd1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
